// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: strobes columns, synchronizes and snapshots rows per sweep,
// debounces whole-sweep snapshots and hands out one encoded event per press.
module keypad_scan_ctrl #(
    parameter int N_COLUMN       = 4,
    parameter int N_ROW          = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    output logic [N_COLUMN-1:0]                 column,
    input  logic [N_ROW-1:0]                    row,
    output logic [$clog2(N_COLUMN*N_ROW)-1:0]   key_code,
    output logic                                key_valid,
    input  logic                                key_ready,
    output logic                                key_held,
    output logic                                overrun
);

    localparam int NK = N_COLUMN * N_ROW;
    localparam int KW = $clog2(NK);
    localparam int CW = (N_COLUMN > 1) ? $clog2(N_COLUMN) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

    typedef enum logic {ARMED, HELD} state_t;

    logic [CW-1:0]    col_idx;
    logic [SW-1:0]    slot_cnt;
    logic [NK-1:0]    snapshot;
    logic [NK-1:0]    snap_full;
    logic [N_ROW-1:0] row_meta_p0;
    logic [N_ROW-1:0] row_sync_p1;
    logic             last_slot;
    logic             sweep_end;
    logic             vld_p1;
    logic             single_p1;
    logic             multi_p1;
    logic [KW-1:0]    idx_p1;
    state_t           state;
    logic [DW-1:0]    deb_cnt;
    logic [DW-1:0]    deb_next;
    logic             deb_done;
    logic [KW-1:0]    candidate;
    logic             emit;
    logic             xfer;

    // {multi, single, index of highest set bit}
    function automatic logic [KW+1:0] classify(input logic [NK-1:0] s);
        int          n;
        logic [KW-1:0] k;
        n = 0;
        k = '0;
        for (int i = 0; i < NK; i++) begin
            if (s[i]) begin
                n++;
                k = KW'(i);
            end
        end
        return {n > 1, n == 1, k};
    endfunction

    assign last_slot = (slot_cnt == SW'(SETTLE_CYCLES - 1));
    assign sweep_end = last_slot && (col_idx == CW'(N_COLUMN - 1));

    // stage p0/p1: two-flop row synchronizer
    always_ff @(posedge clk) begin
        row_meta_p0 <= row;
        row_sync_p1 <= row_meta_p0;
    end

    // the sweep-end classification must include the column being captured this edge
    always_comb begin
        snap_full = snapshot;
        if (last_slot) snap_full[col_idx*N_ROW +: N_ROW] = row_sync_p1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_idx  <= '0;
            slot_cnt <= '0;
            column   <= N_COLUMN'(1);
            snapshot <= '0;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= sweep_end;
            if (last_slot) begin
                slot_cnt <= '0;
                if (col_idx == CW'(N_COLUMN - 1)) begin
                    col_idx <= '0;
                    column  <= N_COLUMN'(1);
                end else begin
                    col_idx <= col_idx + 1'b1;
                    column  <= column << 1;
                end
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
            if (sweep_end)      snapshot <= '0;
            else if (last_slot) snapshot <= snap_full;
        end
    end

    // stage p1: registered sweep classification
    always_ff @(posedge clk) begin
        if (sweep_end) {multi_p1, single_p1, idx_p1} <= classify(snap_full);
    end

    always_comb begin
        deb_next = '0;
        if (state == ARMED) begin
            if (single_p1) deb_next = (idx_p1 == candidate) ? deb_cnt + 1'b1 : DW'(1);
        end else if (!single_p1 && !multi_p1) begin
            deb_next = deb_cnt + 1'b1;
        end
    end

    assign deb_done = (deb_next == DW'(DEBOUNCE_SCANS));
    assign emit     = vld_p1 && (state == ARMED) && deb_done;
    assign xfer     = key_valid && key_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARMED;
            deb_cnt   <= '0;
            candidate <= '0;
            key_held  <= 1'b0;
            key_valid <= 1'b0;
            key_code  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (vld_p1) begin
                if (deb_done) begin
                    deb_cnt <= '0;
                    if (state == ARMED) begin
                        state     <= HELD;
                        key_held  <= 1'b1;
                        candidate <= idx_p1;
                    end else begin
                        state     <= ARMED;
                        key_held  <= 1'b0;
                        candidate <= '0;
                    end
                end else begin
                    deb_cnt <= deb_next;
                    if (state == ARMED && single_p1) candidate <= idx_p1;
                end
            end
            // an event arriving on the transfer edge replaces the one leaving
            if (emit && (!key_valid || xfer)) begin
                key_code  <= idx_p1;
                key_valid <= 1'b1;
                overrun   <= 1'b0;
            end else if (emit) begin
                overrun <= 1'b1;
            end else if (xfer) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

endmodule
